// File: rtl/r4k_pkg.sv
// Shared types and constants for the r4k load/store path.
package r4k_pkg;

  typedef enum logic [3:0] {
    LB  = 4'b0000, LH  = 4'b0001, LW  = 4'b0010, LD  = 4'b0011,
    LBU = 4'b0100, LHU = 4'b0101, LWU = 4'b0110,
    SB  = 4'b1000, SH  = 4'b1001, SW  = 4'b1010, SD  = 4'b1011
  } lsu_op_t;

  typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_RESP} lsu_state_t;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_D = 2'd3;

  localparam int OP_STORE = 3;
  localparam int OP_UNS   = 2;
  localparam int NUM_LANES = 8;

  // Natural alignment: the low log2(size) address bits must be zero.
  function automatic logic is_aligned(input logic [1:0] size, input logic [2:0] lo);
    case (size)
      SZ_B:    is_aligned = 1'b1;
      SZ_H:    is_aligned = ~lo[0];
      SZ_W:    is_aligned = (lo[1:0] == 2'b00);
      default: is_aligned = (lo == 3'b000);
    endcase
  endfunction

endpackage

// File: rtl/r4k_lsu_lane.sv
// Combinational byte-lane datapath: byte-enable mask, store lane shift,
// and load extraction with sign/zero extension.
module r4k_lsu_lane
  import r4k_pkg::*;
(
  input  logic [1:0]           size_i,
  input  logic [2:0]           lo_i,
  input  logic                 uns_i,
  input  logic [63:0]          wdata_i,
  input  logic [63:0]          rdata_i,
  output logic [NUM_LANES-1:0] mask_o,
  output logic [63:0]          wlane_o,
  output logic [63:0]          rvalue_o
);

  logic [NUM_LANES-1:0] span;
  logic [5:0]           bitsh;
  logic [63:0]          shifted;

  assign bitsh   = {lo_i, 3'b000};
  assign wlane_o = wdata_i << bitsh;
  assign mask_o  = span << lo_i;
  assign shifted = rdata_i >> bitsh;

  always_comb begin
    case (size_i)
      SZ_B:    span = 8'h01;
      SZ_H:    span = 8'h03;
      SZ_W:    span = 8'h0F;
      default: span = 8'hFF;
    endcase
  end

  // Doubleword has no extension, so the unsigned flag is moot there.
  always_comb begin
    case (size_i)
      SZ_B:    rvalue_o = {{56{~uns_i & shifted[7]}},  shifted[7:0]};
      SZ_H:    rvalue_o = {{48{~uns_i & shifted[15]}}, shifted[15:0]};
      SZ_W:    rvalue_o = {{32{~uns_i & shifted[31]}}, shifted[31:0]};
      default: rvalue_o = shifted;
    endcase
  end

endmodule

// File: rtl/r4k_lsu.sv
// Load/store unit: one outstanding access, misaligned ops trap without a bus cycle.
module r4k_lsu
  import r4k_pkg::*;
#(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [3:0]        req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [4:0]        req_rd,
  output logic [ADDR_W-1:0] data_address,
  output logic [DATA_W-1:0] data_out,
  input  logic [DATA_W-1:0] data_in,
  output logic              data_read,
  output logic              data_write,
  output logic [7:0]        data_mask,
  input  logic              data_ready,
  output logic              resp_valid,
  output logic              resp_we,
  output logic [4:0]        resp_rd,
  output logic [DATA_W-1:0] resp_value,
  output logic              err_valid,
  output logic              err_store,
  output logic [ADDR_W-1:0] err_addr
);

  lsu_state_t        state_q, state_d;
  logic              store_q, store_d;
  logic              uns_q, uns_d;
  logic [1:0]        size_q, size_d;
  logic [4:0]        rd_q, rd_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rvalue_q, rvalue_d;
  logic              err_q, err_d;

  logic [7:0]        lane_mask;
  logic [DATA_W-1:0] lane_wlane;
  logic [DATA_W-1:0] lane_rvalue;

  r4k_lsu_lane u_lane (
    .size_i   (size_q),
    .lo_i     (addr_q[2:0]),
    .uns_i    (uns_q),
    .wdata_i  (wdata_q),
    .rdata_i  (data_in),
    .mask_o   (lane_mask),
    .wlane_o  (lane_wlane),
    .rvalue_o (lane_rvalue)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      store_q  <= 1'b0;
      uns_q    <= 1'b0;
      size_q   <= SZ_B;
      rd_q     <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rvalue_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      store_q  <= store_d;
      uns_q    <= uns_d;
      size_q   <= size_d;
      rd_q     <= rd_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rvalue_q <= rvalue_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    store_d  = store_q;
    uns_d    = uns_q;
    size_d   = size_q;
    rd_d     = rd_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rvalue_d = rvalue_q;
    err_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          store_d = req_op[OP_STORE];
          uns_d   = req_op[OP_UNS];
          size_d  = req_op[1:0];
          rd_d    = req_rd;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          if (is_aligned(req_op[1:0], req_addr[2:0])) state_d = ST_ACCESS;
          else                                         err_d   = 1'b1;
        end
      end
      ST_ACCESS: begin
        if (data_ready) begin
          rvalue_d = store_q ? '0 : lane_rvalue;
          state_d  = ST_RESP;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Strobes decode straight from state so reset drops them without waiting for a clock.
  assign req_ready    = (state_q == ST_IDLE);
  assign data_read    = (state_q == ST_ACCESS) & ~store_q;
  assign data_write   = (state_q == ST_ACCESS) &  store_q;
  assign data_mask    = (state_q == ST_ACCESS) ? lane_mask : 8'h00;
  assign data_address = {addr_q[ADDR_W-1:3], 3'b000};
  assign data_out     = lane_wlane;

  assign resp_valid = (state_q == ST_RESP);
  assign resp_we    = resp_valid & ~store_q & (rd_q != 5'd0);
  assign resp_rd    = resp_valid ? rd_q : 5'd0;
  assign resp_value = resp_valid ? rvalue_q : '0;

  assign err_valid = err_q;
  assign err_store = err_q & store_q;
  assign err_addr  = err_q ? addr_q : '0;

endmodule

// File: tb/tb_r4k_lsu.sv
// Randomized self-checking bench for r4k_lsu against a byte-level reference model.
module tb_r4k_lsu;
  import r4k_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready;
  logic [3:0]  req_op;
  logic [63:0] req_addr, req_wdata;
  logic [4:0]  req_rd;
  logic [63:0] data_address, data_out, data_in;
  logic        data_read, data_write, data_ready;
  logic [7:0]  data_mask;
  logic        resp_valid, resp_we;
  logic [4:0]  resp_rd;
  logic [63:0] resp_value;
  logic        err_valid, err_store;
  logic [63:0] err_addr;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  r4k_lsu dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
    .data_address(data_address), .data_out(data_out), .data_in(data_in),
    .data_read(data_read), .data_write(data_write), .data_mask(data_mask),
    .data_ready(data_ready),
    .resp_valid(resp_valid), .resp_we(resp_we), .resp_rd(resp_rd), .resp_value(resp_value),
    .err_valid(err_valid), .err_store(err_store), .err_addr(err_addr)
  );

  typedef struct {
    bit ready_acc, ready_bad, err, err_store, rd_seen, wr_seen, stable, resp_we, stray, strobe_after;
    logic [63:0] err_addr, addr, dout, resp_value;
    logic [7:0]  mask;
    logic [4:0]  resp_rd;
    int strobe_cycles, resp_count, resp_cycle;
  } obs_t;

  // ---------------- reference model ----------------
  function automatic int m_nbytes(input logic [3:0] op);
    return 1 << op[1:0];
  endfunction

  function automatic bit m_aligned(input logic [3:0] op, input logic [63:0] a);
    return (a % 64'(m_nbytes(op))) == 64'd0;
  endfunction

  function automatic logic [7:0] m_mask(input logic [3:0] op, input logic [63:0] a);
    logic [7:0] m = 8'h00;
    int lo = int'(a[2:0]);
    for (int i = 0; i < 8; i++) if (i >= lo && i < lo + m_nbytes(op)) m[i] = 1'b1;
    return m;
  endfunction

  function automatic logic [63:0] m_load(input logic [3:0] op, input logic [63:0] a, input logic [63:0] rdata);
    logic [63:0] v = 64'd0;
    int lo = int'(a[2:0]);
    int nb = m_nbytes(op);
    for (int i = 0; i < nb; i++) v[8*i +: 8] = rdata[8*(lo+i) +: 8];
    if (!op[2] && nb < 8 && v[8*nb-1]) v = v - (64'd1 << (8*nb));
    return v;
  endfunction

  // ---------------- driver: performs one op and records what it saw ----------------
  task automatic run_op(input logic [3:0] op, input logic [63:0] a, input logic [63:0] w,
                        input logic [4:0] rd, input logic [63:0] rdata, input int delay,
                        output obs_t o);
    logic [63:0] a0, d0;
    logic [7:0]  m0;
    logic        r0, w0;
    o = '{default: 0};
    o.resp_cycle = -1;
    @(negedge clk);
    req_valid = 1'b1; req_op = op; req_addr = a; req_wdata = w; req_rd = rd;
    o.ready_acc = req_ready;
    @(negedge clk);
    req_valid = 1'b0; req_op = 4'($urandom); req_addr = {$urandom, $urandom};
    req_wdata = {$urandom, $urandom}; req_rd = 5'($urandom);
    if (err_valid) begin
      o.err = 1'b1; o.err_store = err_store; o.err_addr = err_addr;
      o.strobe_after = data_read | data_write;
      @(negedge clk);
      o.stray = err_valid | resp_valid | data_read | data_write;
      return;
    end
    o.stable = 1'b1;
    for (int k = 0; k <= delay; k++) begin
      if (data_read | data_write) o.strobe_cycles++;
      if (k == 0) begin
        a0 = data_address; m0 = data_mask; d0 = data_out; r0 = data_read; w0 = data_write;
        o.addr = data_address; o.mask = data_mask; o.dout = data_out;
      end else if (data_address !== a0 || data_mask !== m0 || data_out !== d0 ||
                   data_read !== r0 || data_write !== w0) o.stable = 1'b0;
      o.rd_seen |= data_read;
      o.wr_seen |= data_write;
      if (req_ready) o.ready_bad = 1'b1;
      data_ready = (k == delay);
      data_in = data_ready ? rdata : {$urandom, $urandom};
      @(negedge clk);
    end
    data_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      if (c == 0) o.strobe_after = data_read | data_write;
      if (resp_valid) begin
        o.resp_count++;
        if (o.resp_cycle < 0) begin
          o.resp_cycle = delay + 2 + c;
          o.resp_we = resp_we; o.resp_rd = resp_rd; o.resp_value = resp_value;
          if (req_ready) o.ready_bad = 1'b1;
        end
      end
      data_ready = 1'($urandom_range(0, 1));
      data_in = {$urandom, $urandom};
      @(negedge clk);
    end
    data_ready = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    total++; if ({data_read, data_write, data_mask} !== 10'd0) begin bad++;
      $display("FAIL reset_strobes got=%h exp=0", {data_read, data_write, data_mask}); end
    total++; if ({resp_valid, resp_we, err_valid, err_store} !== 4'd0) begin bad++;
      $display("FAIL reset_flags got=%b exp=0000", {resp_valid, resp_we, err_valid, err_store}); end
    total++; if ({data_address, data_out, resp_value, err_addr} !== 256'd0) begin bad++;
      $display("FAIL reset_buses got=%h %h exp=0", data_address, data_out); end
    total++; if (req_ready !== 1'b1) begin bad++;
      $display("FAIL reset_ready got=%b exp=1", req_ready); end
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_store_word();
    obs_t o;
    run_op(SW, 64'h1004, 64'hDEADBEEF, 5'd3, 64'd0, 0, o);
    total++; if (o.addr !== 64'h1000) begin bad++; $display("FAIL sw_addr got=%h exp=%h", o.addr, 64'h1000); end
    total++; if (o.mask !== 8'hF0) begin bad++; $display("FAIL sw_mask got=%h exp=f0", o.mask); end
    total++; if (o.dout !== 64'hDEADBEEF_00000000) begin bad++; $display("FAIL sw_dout got=%h exp=deadbeef00000000", o.dout); end
    total++; if (!o.wr_seen || o.rd_seen) begin bad++; $display("FAIL sw_strobe got wr=%b rd=%b exp wr=1 rd=0", o.wr_seen, o.rd_seen); end
    total++; if (o.resp_cycle !== 2) begin bad++; $display("FAIL sw_resp_cycle got=%0d exp=2", o.resp_cycle); end
    total++; if (o.resp_we !== 1'b0 || o.resp_value !== 64'd0) begin bad++;
      $display("FAIL sw_resp got we=%b val=%h exp we=0 val=0", o.resp_we, o.resp_value); end
  endtask

  task automatic test_load_byte();
    obs_t o;
    run_op(LB, 64'h2007, 64'd0, 5'd4, 64'h80123456_78ABCDEF, 1, o);
    total++; if (o.resp_value !== 64'hFFFFFFFF_FFFFFF80) begin bad++; $display("FAIL lb_value got=%h exp=ffffffffffffff80", o.resp_value); end
    total++; if (o.mask !== 8'h80 || !o.rd_seen) begin bad++; $display("FAIL lb_mask got=%h rd=%b exp=80 rd=1", o.mask, o.rd_seen); end
    total++; if (o.resp_we !== 1'b1 || o.resp_rd !== 5'd4) begin bad++; $display("FAIL lb_we got we=%b rd=%0d exp we=1 rd=4", o.resp_we, o.resp_rd); end
    run_op(LBU, 64'h2007, 64'd0, 5'd4, 64'h80123456_78ABCDEF, 0, o);
    total++; if (o.resp_value !== 64'h80) begin bad++; $display("FAIL lbu_value got=%h exp=80", o.resp_value); end
  endtask

  task automatic test_misaligned();
    obs_t o;
    run_op(LW, 64'h2002, 64'd0, 5'd1, 64'd0, 0, o);
    total++; if (o.err !== 1'b1 || o.err_store !== 1'b0 || o.err_addr !== 64'h2002) begin bad++;
      $display("FAIL lw_mis got err=%b st=%b addr=%h exp err=1 st=0 addr=2002", o.err, o.err_store, o.err_addr); end
    total++; if (o.strobe_after || o.stray || o.resp_count != 0) begin bad++;
      $display("FAIL lw_mis_quiet got strobe=%b stray=%b resp=%0d exp 0 0 0", o.strobe_after, o.stray, o.resp_count); end
    run_op(SD, 64'h3004, 64'h1234, 5'd0, 64'd0, 0, o);
    total++; if (o.err !== 1'b1 || o.err_store !== 1'b1 || o.err_addr !== 64'h3004) begin bad++;
      $display("FAIL sd_mis got err=%b st=%b addr=%h exp err=1 st=1 addr=3004", o.err, o.err_store, o.err_addr); end
    run_op(SH, 64'h3001, 64'h1234, 5'd0, 64'd0, 0, o);
    total++; if (o.err !== 1'b1 || o.err_store !== 1'b1) begin bad++;
      $display("FAIL sh_mis got err=%b st=%b exp err=1 st=1", o.err, o.err_store); end
  endtask

  task automatic test_wait_states();
    obs_t o;
    run_op(LD, 64'h4000, 64'd0, 5'd7, 64'h01234567_89ABCDEF, 5, o);
    total++; if (o.strobe_cycles != 6 || !o.stable) begin bad++;
      $display("FAIL ld_wait got cycles=%0d stable=%b exp cycles=6 stable=1", o.strobe_cycles, o.stable); end
    total++; if (o.mask !== 8'hFF || o.addr !== 64'h4000) begin bad++;
      $display("FAIL ld_bus got mask=%h addr=%h exp ff 4000", o.mask, o.addr); end
    total++; if (o.resp_count != 1 || o.resp_cycle != 7 || o.strobe_after) begin bad++;
      $display("FAIL ld_resp got count=%0d cycle=%0d strobe=%b exp 1 7 0", o.resp_count, o.resp_cycle, o.strobe_after); end
    total++; if (o.resp_value !== 64'h01234567_89ABCDEF) begin bad++;
      $display("FAIL ld_value got=%h exp=0123456789abcdef", o.resp_value); end
  endtask

  task automatic test_rd_zero();
    obs_t o;
    run_op(LHU, 64'h6, 64'd0, 5'd0, 64'hBEEF << 48, 0, o);
    total++; if (o.resp_value !== 64'hBEEF || o.resp_count != 1 || o.resp_we !== 1'b0) begin bad++;
      $display("FAIL lhu_rd0 got val=%h cnt=%0d we=%b exp beef 1 0", o.resp_value, o.resp_count, o.resp_we); end
  endtask

  task automatic test_random();
    logic [3:0] ops [15] = '{LB, LH, LW, LD, LBU, LHU, LWU, SB, SH, SW, SD, 4'hC, 4'hD, 4'hE, 4'hF};
    for (int n = 0; n < 60; n++) begin
      obs_t o;
      logic [3:0]  op = ops[$urandom_range(0, 14)];
      logic [63:0] a  = {$urandom, $urandom};
      logic [63:0] w  = {$urandom, $urandom};
      logic [63:0] rdat = {$urandom, $urandom};
      logic [4:0]  rd = 5'($urandom);
      int dly = $urandom_range(0, 3);
      bit st = op[3];
      if ($urandom_range(0, 3) != 0) a = a - (a % 64'(m_nbytes(op)));
      run_op(op, a, w, rd, rdat, dly, o);
      total++; if (o.ready_acc !== 1'b1 || o.ready_bad) begin bad++;
        $display("FAIL rnd%0d_ready got acc=%b busy=%b exp 1 0", n, o.ready_acc, o.ready_bad); end
      total++; if (o.err !== !m_aligned(op, a)) begin bad++;
        $display("FAIL rnd%0d_err op=%h addr=%h got=%b exp=%b", n, op, a, o.err, !m_aligned(op, a)); end
      if (!m_aligned(op, a)) begin
        total++; if (o.err_store !== st || o.err_addr !== a || o.stray || o.strobe_after) begin bad++;
          $display("FAIL rnd%0d_trap got st=%b addr=%h stray=%b exp st=%b addr=%h", n, o.err_store, o.err_addr, o.stray, st, a); end
      end else begin
        total++; if (o.addr !== {a[63:3], 3'b000} || o.mask !== m_mask(op, a)) begin bad++;
          $display("FAIL rnd%0d_bus got addr=%h mask=%h exp addr=%h mask=%h", n, o.addr, o.mask, {a[63:3], 3'b000}, m_mask(op, a)); end
        total++; if (o.wr_seen !== st || o.rd_seen !== !st || !o.stable || o.strobe_cycles != dly + 1 || o.strobe_after) begin bad++;
          $display("FAIL rnd%0d_strobe got wr=%b rd=%b stable=%b cyc=%0d exp wr=%b cyc=%0d", n, o.wr_seen, o.rd_seen, o.stable, o.strobe_cycles, st, dly + 1); end
        if (st) begin
          total++; if (o.dout !== (w << (8 * int'(a[2:0])))) begin bad++;
            $display("FAIL rnd%0d_dout got=%h exp=%h", n, o.dout, w << (8 * int'(a[2:0]))); end
        end
        total++; if (o.resp_count != 1 || o.resp_cycle != dly + 2) begin bad++;
          $display("FAIL rnd%0d_resp got cnt=%0d cyc=%0d exp 1 %0d", n, o.resp_count, o.resp_cycle, dly + 2); end
        total++; if (o.resp_value !== (st ? 64'd0 : m_load(op, a, rdat)) || o.resp_we !== (!st && rd != 0) || o.resp_rd !== rd) begin bad++;
          $display("FAIL rnd%0d_wb op=%h got val=%h we=%b rd=%0d exp val=%h rd=%0d", n, op, o.resp_value, o.resp_we, o.resp_rd,
                   st ? 64'd0 : m_load(op, a, rdat), rd); end
      end
    end
  endtask

  task automatic test_reset_mid();
    bit stray = 1'b0;
    @(negedge clk);
    req_valid = 1'b1; req_op = LD; req_addr = 64'h5000; req_rd = 5'd9;
    @(negedge clk);
    req_valid = 1'b0; data_ready = 1'b0;
    total++; if (data_read !== 1'b1) begin bad++; $display("FAIL mid_pre got rd=%b exp=1", data_read); end
    #2 reset = 1'b0;
    #1;
    total++; if ({data_read, data_write, data_mask} !== 10'd0) begin bad++;
      $display("FAIL mid_async got=%h exp=0", {data_read, data_write, data_mask}); end
    @(negedge clk);
    reset = 1'b1;
    for (int c = 0; c < 5; c++) begin
      if (!req_ready || resp_valid || err_valid || data_read || data_write) stray = 1'b1;
      data_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    data_ready = 1'b0;
    total++; if (stray) begin bad++; $display("FAIL mid_after got stray=1 exp=0"); end
  endtask

  initial begin
    req_valid = 1'b0; req_op = 4'd0; req_addr = 64'd0; req_wdata = 64'd0; req_rd = 5'd0;
    data_in = 64'd0; data_ready = 1'b0; reset = 1'b0;
    test_reset();
    test_store_word();
    test_load_byte();
    test_misaligned();
    test_wait_states();
    test_rd_zero();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
